// File: rtl/pulse_stretcher_pkg.sv
// rtl/pulse_stretcher_pkg.sv - state encodings and sizing helper for the pulse stretcher
package pulse_stretcher_pkg;

    localparam logic [1:0] ENC_IDLE = 2'd0;
    localparam logic [1:0] ENC_HIGH = 2'd1;
    localparam logic [1:0] ENC_LOW  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ENC_IDLE,
        ST_HIGH = ENC_HIGH,
        ST_LOW  = ENC_LOW
    } state_t;

    // Phase timer must hold the larger of the two terminal values.
    function automatic int cnt_width(input int high_cycles, input int low_cycles);
        int longest;
        longest = (high_cycles > low_cycles) ? high_cycles : low_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/pulse_stretcher_if.sv
// rtl/pulse_stretcher_if.sv - event strobe in, stretched pulse and status out
interface pulse_stretcher_if #(
    parameter int PEND_W = 4
);
    logic              i_event;
    logic              o_out;
    logic              o_busy;
    logic [PEND_W-1:0] o_pending;
    logic              o_drop;

    modport master (
        output i_event,
        input  o_out, o_busy, o_pending, o_drop
    );

    modport slave (
        input  i_event,
        output o_out, o_busy, o_pending, o_drop
    );
endinterface

// File: rtl/pulse_timer.sv
// rtl/pulse_timer.sv - phase timer that stops at its limit and never wraps
module pulse_timer #(
    parameter int CNT_W = 7
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_done
);

    logic [CNT_W-1:0] count;

    assign o_done = i_en && (count == i_limit);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (i_clear) begin
            count <= '0;
        end else if (i_en && !o_done) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - stretches event strobes into queued blinks with min high/low times
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int HIGH_CYCLES = 99,
    parameter int LOW_CYCLES  = 99,
    parameter int PEND_W      = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    pulse_stretcher_if.slave   bus
);

    localparam int               CNT_W      = cnt_width(HIGH_CYCLES, LOW_CYCLES);
    localparam logic [CNT_W-1:0] HIGH_LIMIT = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOW_LIMIT  = CNT_W'(LOW_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

    state_t            state;
    logic              out_q;
    logic              busy_q;
    logic [PEND_W-1:0] pending;
    logic              drop_q;

    logic              timer_en;
    logic              timer_clear;
    logic              timer_done;
    logic [CNT_W-1:0]  timer_limit;

    logic              low_end;
    logic              consume;
    logic              incr;
    logic [PEND_W-1:0] pending_next;
    logic              drop_next;

    assign timer_en    = (state != ST_IDLE);
    assign timer_limit = (state == ST_LOW) ? LOW_LIMIT : HIGH_LIMIT;
    assign timer_clear = (state == ST_IDLE) || timer_done;

    pulse_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (timer_clear),
        .i_en    (timer_en),
        .i_limit (timer_limit),
        .o_done  (timer_done)
    );

    // An event landing on the last LOW cycle with nothing queued starts the
    // next blink directly, so it is neither queued nor consumed.
    assign low_end = (state == ST_LOW) && timer_done;
    assign consume = low_end && (pending != '0);
    assign incr    = timer_en && bus.i_event && !(low_end && (pending == '0));

    always_comb begin
        pending_next = pending;
        drop_next    = 1'b0;
        if (incr && !consume) begin
            if (pending == PEND_MAX) begin
                drop_next = 1'b1;
            end else begin
                pending_next = pending + 1'b1;
            end
        end else if (consume && !incr) begin
            pending_next = pending - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            pending <= '0;
            drop_q  <= 1'b0;
        end else begin
            pending <= pending_next;
            drop_q  <= drop_next;
            case (state)
                ST_IDLE: begin
                    if (bus.i_event) begin
                        state  <= ST_HIGH;
                        out_q  <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (timer_done) begin
                        state <= ST_LOW;
                        out_q <= 1'b0;
                    end
                end
                ST_LOW: begin
                    if (timer_done) begin
                        if ((pending != '0) || bus.i_event) begin
                            state <= ST_HIGH;
                            out_q <= 1'b1;
                        end else begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    out_q  <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_out     = out_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_pending = pending;
    assign bus.o_drop    = drop_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - directed-vector bench for pulse_stretcher (HIGH=4, LOW=3, PEND_W=2)
module tb_pulse_stretcher;

    localparam int HC   = 4;
    localparam int LC   = 3;
    localparam int PW   = 2;
    localparam int NCYC = 48;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;

    pulse_stretcher_if #(.PEND_W(PW)) bus ();

    pulse_stretcher #(
        .HIGH_CYCLES (HC),
        .LOW_CYCLES  (LC),
        .PEND_W      (PW)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    logic          out_r  [NCYC];
    logic          busy_r [NCYC];
    logic [PW-1:0] pend_r [NCYC];
    logic          drop_r [NCYC];

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    // Reset, then step NCYC cycles; inputs change 1 time unit after the edge, outputs sampled on the falling edge.
    task automatic run(input logic [NCYC-1:0] ev, input int rst_cyc);
        bus.i_event = 1'b0;
        i_rst_n     = 1'b0;
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge i_clk);
            #1;
            bus.i_event = ev[c];
            if (c == rst_cyc) i_rst_n = 1'b0;
            else if (c == rst_cyc + 1) i_rst_n = 1'b1;
            @(negedge i_clk);
            out_r[c]  = bus.o_out;
            busy_r[c] = bus.o_busy;
            pend_r[c] = bus.o_pending;
            drop_r[c] = bus.o_drop;
        end
        bus.i_event = 1'b0;
    endtask

    function automatic int rises(input int from);
        int n = 0;
        for (int c = from + 1; c < NCYC; c++) if (out_r[c] && !out_r[c-1]) n++;
        return n;
    endfunction

    function automatic int max_pend();
        int m = 0;
        for (int c = 0; c < NCYC; c++) if (int'(pend_r[c]) > m) m = int'(pend_r[c]);
        return m;
    endfunction

    function automatic int count_drop();
        int n = 0;
        for (int c = 0; c < NCYC; c++) if (drop_r[c]) n++;
        return n;
    endfunction

    function automatic int busy_span(input int from, input int to);
        int n = 0;
        for (int c = from; c <= to; c++) if (busy_r[c]) n++;
        return n;
    endfunction

    function automatic int high_span(input int from, input int to);
        int n = 0;
        for (int c = from; c <= to; c++) if (out_r[c]) n++;
        return n;
    endfunction

    logic [NCYC-1:0] ev;

    initial begin
        bus.i_event = 1'b0;
        repeat (2) @(negedge i_clk);
        check("rst_out",     32'(bus.o_out),     0);
        check("rst_busy",    32'(bus.o_busy),    0);
        check("rst_pending", 32'(bus.o_pending), 0);
        check("rst_drop",    32'(bus.o_drop),    0);

        // single event
        ev = '0; ev[10] = 1'b1;
        run(ev, -1);
        check("t1_out10",  32'(out_r[10]),  0);
        check("t1_out11",  32'(out_r[11]),  1);
        check("t1_out14",  32'(out_r[14]),  1);
        check("t1_out15",  32'(out_r[15]),  0);
        check("t1_busy10", 32'(busy_r[10]), 0);
        check("t1_busy17", 32'(busy_r[17]), 1);
        check("t1_busy18", 32'(busy_r[18]), 0);
        check("t1_rises",  32'(rises(0)),   1);

        // queued events
        ev = '0; ev[10] = 1'b1; ev[12] = 1'b1; ev[13] = 1'b1;
        run(ev, -1);
        check("t2_maxpend", 32'(max_pend()), 2);
        check("t2_out17",   32'(out_r[17]),  0);
        check("t2_out18",   32'(out_r[18]),  1);
        check("t2_out24",   32'(out_r[24]),  0);
        check("t2_out25",   32'(out_r[25]),  1);
        check("t2_busy31",  32'(busy_r[31]), 1);
        check("t2_busy32",  32'(busy_r[32]), 0);
        check("t2_rises",   32'(rises(0)),   3);

        // saturation
        ev = '0;
        for (int c = 10; c <= 15; c++) ev[c] = 1'b1;
        run(ev, -1);
        check("t3_maxpend", 32'(max_pend()),   3);
        check("t3_drops",   32'(count_drop()), 2);
        check("t3_drop15",  32'(drop_r[15]),   1);
        check("t3_drop16",  32'(drop_r[16]),   1);
        check("t3_rises",   32'(rises(0)),     4);
        check("t3_busy39",  32'(busy_r[39]),   0);

        // event in the last LOW cycle with nothing pending
        ev = '0; ev[10] = 1'b1; ev[17] = 1'b1;
        run(ev, -1);
        check("t4_out17",   32'(out_r[17]),  0);
        check("t4_out18",   32'(out_r[18]),  1);
        check("t4_maxpend", 32'(max_pend()), 0);
        check("t4_busy",    32'(busy_span(11, 24)), 14);
        check("t4_busy25",  32'(busy_r[25]), 0);
        check("t4_rises",   32'(rises(0)),   2);

        // event coincides with consume of a pending entry
        ev = '0; ev[10] = 1'b1; ev[12] = 1'b1; ev[17] = 1'b1;
        run(ev, -1);
        check("t5_pend17", 32'(pend_r[17]), 1);
        check("t5_pend18", 32'(pend_r[18]), 1);
        check("t5_out18",  32'(out_r[18]),  1);
        check("t5_pend25", 32'(pend_r[25]), 0);
        check("t5_out25",  32'(out_r[25]),  1);
        check("t5_busy",   32'(busy_span(11, 31)), 21);
        check("t5_busy32", 32'(busy_r[32]), 0);
        check("t5_rises",  32'(rises(0)),   3);

        // reset mid-pulse
        ev = '0; ev[10] = 1'b1; ev[11] = 1'b1; ev[15] = 1'b1;
        run(ev, 12);
        check("t6_out11",   32'(out_r[11]),  1);
        check("t6_pend11",  32'(pend_r[11]), 0);
        check("t6_out12",   32'(out_r[12]),  0);
        check("t6_busy12",  32'(busy_r[12]), 0);
        check("t6_pend12",  32'(pend_r[12]), 0);
        check("t6_out16",   32'(out_r[16]),  1);
        check("t6_out20",   32'(out_r[20]),  0);
        check("t6_highlen", 32'(high_span(13, NCYC-1)), 4);
        check("t6_rises",   32'(rises(13)),  1);
        check("t6_busy23",  32'(busy_r[23]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
